// File: rtl/wb_stage_buf.sv
// wb_stage_buf: registered write-back stage with a 2-entry skid FIFO.
//
// Purpose:
//   Picks the write-back value for each retiring instruction and queues it
//   for the register file write port. The value is the ALU result, the
//   extracted and extended load data, or the call link value (pc + PC_INC).
//   The 2-entry FIFO lets the register file back-pressure the stage. The
//   youngest buffered result is exposed for forwarding, and a wrapping
//   counter tracks retired instructions.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_*              instruction from the memory stage (valid/ready handshake)
//   wr_en/addr/data   register file write request, head of the FIFO
//   wr_ready          register file accepts the head write this cycle
//   fwd_*             youngest buffered entry (zero when empty)
//   retire_count      instructions retired (writes popped plus non-writing accepts)
module wb_stage_buf #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 4,
  parameter int LINK_REG   = 15,
  parameter int PC_INC     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_iswb,
  input  logic                  in_iscall,
  input  logic                  in_isld,
  input  logic [1:0]            in_ld_size,
  input  logic                  in_ld_unsigned,
  input  logic [1:0]            in_ld_offset,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [DATA_W-1:0]     in_aluresult,
  input  logic [DATA_W-1:0]     in_ldresult,
  input  logic [DATA_W-1:0]     in_pc,
  input  logic                  wr_ready,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      retire_count
);

  // FIFO state: two entries addressed by a head pointer plus an occupancy count.
  logic [1:0]            count_q, count_d;
  logic                  head_q, head_d;
  logic [REG_ADDR_W-1:0] addr_q [2];
  logic [REG_ADDR_W-1:0] addr_d [2];
  logic [DATA_W-1:0]     data_q [2];
  logic [DATA_W-1:0]     data_d [2];
  logic [CNT_W-1:0]      retire_q, retire_d;

  logic                  accept, push, pop, accept_nowb;
  logic                  tail_idx, young_idx;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_W-1:0]     ld_data;
  logic [REG_ADDR_W-1:0] new_addr;
  logic [DATA_W-1:0]     new_data;

  // in_ready is a function of registered occupancy only, so wr_ready never
  // reaches it combinationally.
  assign in_ready    = (count_q != 2'd2);
  assign wr_en       = (count_q != 2'd0);
  assign accept      = in_valid && in_ready;
  assign push        = accept && in_iswb;
  assign accept_nowb = accept && !in_iswb;
  assign pop         = wr_en && wr_ready;

  // With one entry the tail slot is the one after head; otherwise it is head.
  assign tail_idx  = head_q ^ (count_q == 2'd1);
  assign young_idx = (count_q == 2'd2) ? ~head_q : head_q;

  assign wr_addr      = wr_en ? addr_q[head_q] : '0;
  assign wr_data      = wr_en ? data_q[head_q] : '0;
  assign fwd_valid    = wr_en;
  assign fwd_addr     = wr_en ? addr_q[young_idx] : '0;
  assign fwd_data     = wr_en ? data_q[young_idx] : '0;
  assign retire_count = retire_q;

  // Sub-word load extraction from bits [31:0].
  always_comb begin
    ld_byte = 8'd0;
    ld_data = in_ldresult;
    case (in_ld_offset)
      2'd0:    ld_byte = in_ldresult[7:0];
      2'd1:    ld_byte = in_ldresult[15:8];
      2'd2:    ld_byte = in_ldresult[23:16];
      default: ld_byte = in_ldresult[31:24];
    endcase
    // Halfword alignment ignores offset bit 0.
    ld_half = in_ld_offset[1] ? in_ldresult[31:16] : in_ldresult[15:0];
    case (in_ld_size)
      2'd0:    ld_data = {{(DATA_W-8){ld_byte[7] & ~in_ld_unsigned}}, ld_byte};
      2'd1:    ld_data = {{(DATA_W-16){ld_half[15] & ~in_ld_unsigned}}, ld_half};
      default: ld_data = in_ldresult;  // word; upper bits pass through
    endcase
  end

  // Source select: call beats load beats ALU.
  always_comb begin
    new_addr = in_rd;
    new_data = in_aluresult;
    if (in_iscall) begin
      new_addr = REG_ADDR_W'(LINK_REG);
      new_data = in_pc + DATA_W'(PC_INC);
    end else if (in_isld) begin
      new_data = ld_data;
    end
  end

  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    retire_d = retire_q + CNT_W'(pop) + CNT_W'(accept_nowb);
    for (int i = 0; i < 2; i++) begin
      addr_d[i] = addr_q[i];
      data_d[i] = data_q[i];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (pop) begin
      head_d = ~head_q;
    end
    // A push into EMPTY lands in the head slot and cannot be popped this edge
    // because pop needs a registered valid entry.
    if (push) begin
      addr_d[tail_idx] = new_addr;
      data_d[tail_idx] = new_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= 2'd0;
      head_q   <= 1'b0;
      retire_q <= '0;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      head_q   <= head_d;
      retire_q <= retire_d;
      for (int i = 0; i < 2; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_wb_stage_buf.sv
// Testbench for wb_stage_buf: table-driven single-instruction vectors plus
// hand-written back-pressure, simultaneous-retire and reset sequences.
module tb_wb_stage_buf;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_iswb;
  logic        in_iscall;
  logic        in_isld;
  logic [1:0]  in_ld_size;
  logic        in_ld_unsigned;
  logic [1:0]  in_ld_offset;
  logic [3:0]  in_rd;
  logic [31:0] in_aluresult;
  logic [31:0] in_ldresult;
  logic [31:0] in_pc;
  logic        wr_ready;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        fwd_valid;
  logic [3:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] retire_count;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_retire;

  wb_stage_buf dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_iswb(in_iswb),
    .in_iscall(in_iscall), .in_isld(in_isld), .in_ld_size(in_ld_size),
    .in_ld_unsigned(in_ld_unsigned), .in_ld_offset(in_ld_offset),
    .in_rd(in_rd), .in_aluresult(in_aluresult), .in_ldresult(in_ldresult),
    .in_pc(in_pc), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .fwd_data(fwd_data), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        iscall;
    logic        isld;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  off;
    logic [3:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
    logic [31:0] pc;
    logic [3:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs [12];

  task automatic idle_inputs();
    in_valid = 0; in_iswb = 0; in_iscall = 0; in_isld = 0;
    in_ld_size = 2'd0; in_ld_unsigned = 0; in_ld_offset = 2'd0;
    in_rd = 4'd0; in_aluresult = 32'd0; in_ldresult = 32'd0; in_pc = 32'd0;
  endtask

  task automatic drive_alu(input logic [3:0] rd, input logic [31:0] alu, input logic wb);
    idle_inputs();
    in_valid = 1; in_iswb = wb; in_rd = rd; in_aluresult = alu;
  endtask

  initial begin
    //            call ld size uns off rd   alu        ld            pc            addr  data
    vecs[0]  = '{1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 4'd3, 32'h0000_1234, 32'h0, 32'h0, 4'd3, 32'h0000_1234};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 1'b0, 2'd0, 4'd5, 32'hDEAD_0000, 32'h80FF_7F01, 32'h0000_0100, 4'd15, 32'h0000_0104};
    vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd2, 4'd7, 32'h0, 32'h80FF_7F01, 32'h0, 4'd7, 32'hFFFF_FFFF};
    vecs[3]  = '{1'b0, 1'b1, 2'd0, 1'b1, 2'd0, 4'd8, 32'h0, 32'h80FF_7F01, 32'h0, 4'd8, 32'h0000_0001};
    vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd2, 4'd9, 32'h0, 32'h80FF_7F01, 32'h0, 4'd9, 32'hFFFF_80FF};
    vecs[5]  = '{1'b0, 1'b1, 2'd2, 1'b0, 2'd1, 4'd10, 32'h0, 32'h80FF_7F01, 32'h0, 4'd10, 32'h80FF_7F01};
    vecs[6]  = '{1'b0, 1'b1, 2'd0, 1'b0, 2'd1, 4'd11, 32'h0, 32'h80FF_7F01, 32'h0, 4'd11, 32'h0000_007F};
    vecs[7]  = '{1'b0, 1'b1, 2'd0, 1'b1, 2'd3, 4'd12, 32'h0, 32'h80FF_7F01, 32'h0, 4'd12, 32'h0000_0080};
    vecs[8]  = '{1'b0, 1'b1, 2'd1, 1'b0, 2'd1, 4'd13, 32'h0, 32'h80FF_7F01, 32'h0, 4'd13, 32'h0000_7F01};
    vecs[9]  = '{1'b0, 1'b1, 2'd1, 1'b1, 2'd3, 4'd14, 32'h0, 32'h80FF_7F01, 32'h0, 4'd14, 32'h0000_80FF};
    vecs[10] = '{1'b0, 1'b1, 2'd3, 1'b1, 2'd0, 4'd1, 32'h0, 32'h80FF_7F01, 32'h0, 4'd1, 32'h80FF_7F01};
    vecs[11] = '{1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 4'd2, 32'h5, 32'h0, 32'hFFFF_FFFE, 4'd15, 32'h0000_0002};

    idle_inputs();
    wr_ready = 1;
    rst = 1;
    exp_retire = 0;
    #1;
    check("reset_wr_en", {31'd0, wr_en}, 32'd0);
    check("reset_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("reset_retire", retire_count, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 0;

    // Single-instruction vectors through an empty FIFO with wr_ready=1.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      idle_inputs();
      in_valid = 1; in_iswb = 1;
      in_iscall = vecs[i].iscall; in_isld = vecs[i].isld;
      in_ld_size = vecs[i].size; in_ld_unsigned = vecs[i].uns;
      in_ld_offset = vecs[i].off; in_rd = vecs[i].rd;
      in_aluresult = vecs[i].alu; in_ldresult = vecs[i].ld; in_pc = vecs[i].pc;
      @(negedge clk);
      idle_inputs();
      check($sformatf("vec%0d_wr_en", i), {31'd0, wr_en}, 32'd1);
      check($sformatf("vec%0d_wr_addr", i), {28'd0, wr_addr}, {28'd0, vecs[i].exp_addr});
      check($sformatf("vec%0d_wr_data", i), wr_data, vecs[i].exp_data);
      check($sformatf("vec%0d_fwd_data", i), fwd_data, vecs[i].exp_data);
      @(negedge clk);
      exp_retire = exp_retire + 1;
      check($sformatf("vec%0d_popped", i), {31'd0, wr_en}, 32'd0);
      check($sformatf("vec%0d_retire", i), retire_count, exp_retire);
      $display("vec %0d: addr=%0d data=0x%08h retire=%0d", i, wr_addr, vecs[i].exp_data, retire_count);
    end

    // Back-pressure: fill to FULL, hold, then drain with a push/pop in ONE.
    wr_ready = 0;
    drive_alu(4'd1, 32'h11, 1'b1);
    @(negedge clk);
    check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    drive_alu(4'd2, 32'h22, 1'b1);
    @(negedge clk);
    check("bp_ready_full", {31'd0, in_ready}, 32'd0);
    check("bp_head_addr", {28'd0, wr_addr}, 32'd1);
    check("bp_head_data", wr_data, 32'h11);
    check("bp_fwd_addr", {28'd0, fwd_addr}, 32'd2);
    check("bp_fwd_data", fwd_data, 32'h22);
    drive_alu(4'd4, 32'h44, 1'b1);
    @(negedge clk);
    check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    check("bp_hold_data", wr_data, 32'h11);
    check("bp_hold_retire", retire_count, exp_retire);
    wr_ready = 1;
    @(negedge clk);
    exp_retire = exp_retire + 1;
    check("bp_second_addr", {28'd0, wr_addr}, 32'd2);
    check("bp_second_data", wr_data, 32'h22);
    check("bp_ready_one", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    exp_retire = exp_retire + 1;
    idle_inputs();
    check("bp_third_addr", {28'd0, wr_addr}, 32'd4);
    check("bp_third_data", wr_data, 32'h44);
    check("bp_third_fwd", {28'd0, fwd_addr}, 32'd4);
    @(negedge clk);
    exp_retire = exp_retire + 1;
    check("bp_drained", {31'd0, wr_en}, 32'd0);
    check("bp_retire", retire_count, exp_retire);
    $display("backpressure: retire=%0d", retire_count);

    // Non-writing accept in the same edge as a pop: retire +2.
    drive_alu(4'd6, 32'hA, 1'b1);
    @(negedge clk);
    check("nowb_pending", {31'd0, wr_en}, 32'd1);
    drive_alu(4'd7, 32'hB, 1'b0);
    @(negedge clk);
    idle_inputs();
    exp_retire = exp_retire + 2;
    check("nowb_retire2", retire_count, exp_retire);
    check("nowb_no_wr", {31'd0, wr_en}, 32'd0);
    $display("nowb: retire=%0d", retire_count);

    // Reset while FULL and stalled.
    wr_ready = 0;
    drive_alu(4'd3, 32'h33, 1'b1);
    @(negedge clk);
    drive_alu(4'd5, 32'h55, 1'b1);
    @(negedge clk);
    idle_inputs();
    check("rst_pre_full", {31'd0, in_ready}, 32'd0);
    #2 rst = 1;
    #1;
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_fwd_addr", {28'd0, fwd_addr}, 32'd0);
    check("rst_fwd_valid", {31'd0, fwd_valid}, 32'd0);
    check("rst_retire", retire_count, 32'd0);
    @(negedge clk);
    rst = 0;
    exp_retire = 0;
    wr_ready = 1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("rst_no_stale", {31'd0, wr_en}, 32'd0);
    check("rst_retire_after", retire_count, exp_retire);
    $display("reset: wr_en=%0d retire=%0d", wr_en, retire_count);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
